// File: rtl/mopshub_bus_pkg.sv
// ---------------------------------------------------------------------------
// mopshub_bus_pkg
// Shared definitions for the bus flag scanner:
//   N_BUS_DEFAULT  default number of bus channels
//   scan_state_t   grant FSM state encoding (IDLE / SCAN / OFFER)
//   idx_width()    channel index width for a given channel count
// Build option: BUS_FLAG_SCAN_RR_EN selects round-robin picking in the
// scanner; without it the scanner uses fixed lowest-index priority.
// ---------------------------------------------------------------------------
package mopshub_bus_pkg;

    localparam int N_BUS_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        OFFER = 2'd2
    } scan_state_t;

    // Index width for n channels, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_flag_pick.sv
// ---------------------------------------------------------------------------
// bus_flag_pick
// Combinational picker: finds the set flag to offer next.
// Build option BUS_FLAG_SCAN_RR_EN:
//   defined   -> first set flag at or above ptr, wrapping (round-robin)
//   undefined -> lowest-index set flag (fixed priority), no ptr port
// Ports:
//   vec    in   N_BUS  flag vector to search
//   ptr    in   SEL_W  round-robin start channel (RR build only)
//   index  out  SEL_W  picked channel (0 when nothing found)
//   found  out  1      at least one flag is set
// ---------------------------------------------------------------------------
module bus_flag_pick
    import mopshub_bus_pkg::*;
#(
    parameter int N_BUS = N_BUS_DEFAULT,
    parameter int SEL_W = idx_width(N_BUS)
) (
    input  logic [N_BUS-1:0] vec,
`ifdef BUS_FLAG_SCAN_RR_EN
    input  logic [SEL_W-1:0] ptr,
`endif
    output logic [SEL_W-1:0] index,
    output logic             found
);

    int pos;

    // Walk the channels in search order and keep the first hit.
    always_comb begin
        index = '0;
        found = 1'b0;
        pos   = 0;
        for (int i = 0; i < N_BUS; i++) begin
`ifdef BUS_FLAG_SCAN_RR_EN
            pos = int'(ptr) + i;
            if (pos >= N_BUS) begin
                pos = pos - N_BUS;
            end
`else
            pos = i;
`endif
            if (!found && vec[pos[SEL_W-1:0]]) begin
                found = 1'b1;
                index = pos[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/bus_flag_scan.sv
// ---------------------------------------------------------------------------
// bus_flag_scan
// Holds a vector of per-channel pending flags and offers one pending channel
// at a time to a consumer through a valid/ready handshake.
// Build option BUS_FLAG_SCAN_RR_EN: round-robin channel selection with a
// pointer that advances past each accepted channel; without it the lowest
// pending index always wins.
// Ports:
//   clk          in   1        clock, rising edge
//   rst          in   1        asynchronous reset, active low
//   load_en      in   1        replace the whole flag vector with load_data
//   load_data    in   N_BUS    new flag vector
//   set_en       in   1        set flags[set_sel]
//   set_sel      in   SEL_W    channel to set (>= N_BUS ignored)
//   clr_en       in   1        clear flags[clr_sel]
//   clr_sel      in   SEL_W    channel to clear (>= N_BUS ignored)
//   flags        out  N_BUS    registered flag vector
//   pend_cnt     out  SEL_W+1  registered popcount of flags
//   grant_valid  out  1        a channel is being offered
//   grant_sel    out  SEL_W    offered channel, stable while grant_valid
//   grant_ready  in   1        consumer accepts the offer
// ---------------------------------------------------------------------------
module bus_flag_scan
    import mopshub_bus_pkg::*;
#(
    parameter int N_BUS = N_BUS_DEFAULT,
    parameter int SEL_W = idx_width(N_BUS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [N_BUS-1:0] load_data,
    input  logic             set_en,
    input  logic [SEL_W-1:0] set_sel,
    input  logic             clr_en,
    input  logic [SEL_W-1:0] clr_sel,
    output logic [N_BUS-1:0] flags,
    output logic [SEL_W:0]   pend_cnt,
    output logic             grant_valid,
    output logic [SEL_W-1:0] grant_sel,
    input  logic             grant_ready
);

    scan_state_t      state;
    scan_state_t      state_nxt;
    logic [N_BUS-1:0] flags_nxt;
    logic [SEL_W:0]   cnt_nxt;
    logic             accept;
    logic             set_ok;
    logic             clr_ok;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;
`ifdef BUS_FLAG_SCAN_RR_EN
    logic [SEL_W-1:0] ptr;
`endif

    assign set_ok = set_en && (int'(set_sel) < N_BUS);
    assign clr_ok = clr_en && (int'(clr_sel) < N_BUS);

    // Lowest-priority action is applied first so later ones override it:
    // accept-clear, then set (keeps a re-requested channel), then clear.
    always_comb begin
        flags_nxt = flags;
        if (load_en) begin
            flags_nxt = load_data;
        end else begin
            if (accept) begin
                flags_nxt[grant_sel] = 1'b0;
            end
            if (set_ok) begin
                flags_nxt[set_sel] = 1'b1;
            end
            if (clr_ok) begin
                flags_nxt[clr_sel] = 1'b0;
            end
        end
    end

    // Count is taken from the next vector so it lands with flags.
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < N_BUS; i++) begin
            cnt_nxt = cnt_nxt + (SEL_W+1)'(flags_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags    <= '0;
            pend_cnt <= '0;
        end else begin
            flags    <= flags_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

    // The picker looks at the vector as it will be when OFFER begins, so a
    // flag cleared during SCAN is never offered.
    bus_flag_pick #(
        .N_BUS (N_BUS),
        .SEL_W (SEL_W)
    ) u_pick (
        .vec   (flags_nxt),
`ifdef BUS_FLAG_SCAN_RR_EN
        .ptr   (ptr),
`endif
        .index (pick_idx),
        .found (pick_found)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Leaving OFFER without accept happens when load/clr removed the
    // offered flag; set can only raise flags so it never causes this.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (|flags) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                state_nxt = pick_found ? OFFER : IDLE;
            end
            OFFER: begin
                if (accept || !flags_nxt[grant_sel]) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        grant_valid = (state == OFFER);
        accept      = grant_valid && grant_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_sel <= '0;
        end else if (state == SCAN && pick_found) begin
            grant_sel <= pick_idx;
        end
    end

`ifdef BUS_FLAG_SCAN_RR_EN
    // Search restarts just past the channel that was served.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (int'(grant_sel) == N_BUS - 1) ? '0 : grant_sel + 1'b1;
        end
    end
`endif

endmodule
